// File: rtl/buff_uart_bus_arbiter_pkg.sv
// Shared types for masters of the buff_uart register bus: arbiter FSM states,
// the command record a requester presents, and a grant-index width helper.
package buff_uart_bus_arbiter_pkg;

   localparam int BUS_WIDTH  = 8;
   localparam int BUS_ADDR_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  write;
      logic [BUS_ADDR_W-1:0] address;
      logic [BUS_WIDTH-1:0]  wdata;
   } bus_cmd_t;

   // A single requester still needs a 1-bit index signal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/buff_uart_bus_arbiter_if.sv
// Requester-side command/response signals plus the buff_uart bus port, as seen by
// the arbiter (slave modport) and by everything around it (master modport).
interface buff_uart_bus_arbiter_if #(
   parameter int NUM_REQ       = 4,
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4
);
   import buff_uart_bus_arbiter_pkg::*;

   localparam int IDW = id_width(NUM_REQ);

   // Handshake: requester i raises req_valid[i] with write/address/wdata stable and
   // holds them until the cycle req_ready[i] is high; the command transfers in that
   // cycle. It may not withdraw. Completion is a single-cycle resp_valid[i] pulse,
   // with resp_rdata meaningful for reads in that same cycle.
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0]               req_write;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
   logic [NUM_REQ*WIDTH-1:0]         req_wdata;
   logic [NUM_REQ-1:0]               resp_valid;
   logic [WIDTH-1:0]                 resp_rdata;
   logic [IDW-1:0]                   grant_id;
   logic [ADDRESS_WIDTH-1:0]         bus_active_address;
   logic                             bus_write_enable;
   logic                             bus_read_enable;
   logic [WIDTH-1:0]                 bus_data_in;
   logic [WIDTH-1:0]                 bus_data_out;

   modport master (
      output req_valid, req_write, req_address, req_wdata, bus_data_out,
      input  req_ready, resp_valid, resp_rdata, grant_id,
      input  bus_active_address, bus_write_enable, bus_read_enable, bus_data_in
   );

   modport slave (
      input  req_valid, req_write, req_address, req_wdata, bus_data_out,
      output req_ready, resp_valid, resp_rdata, grant_id,
      output bus_active_address, bus_write_enable, bus_read_enable, bus_data_in
   );

endinterface

// File: rtl/buff_uart_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns a onehot grant, its index and whether anything was requesting.
module buff_uart_bus_arbiter_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   // First pass covers ptr..NUM_REQ-1, second pass the wrapped part 0..ptr-1.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req[i] && (IDW'(i) >= ptr)) begin
            any = 1'b1;
            idx = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req[i]) begin
            any = 1'b1;
            idx = IDW'(i);
         end
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/buff_uart_bus_arbiter.sv
// Round-robin arbiter sharing one buff_uart register bus among NUM_REQ requesters;
// one transaction in flight, single-cycle bus strobe, fixed read latency.
module buff_uart_bus_arbiter
   import buff_uart_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int READ_LATENCY  = 1
) (
   input  logic                   clock,
   input  logic                   resetn,
   buff_uart_bus_arbiter_if.slave bus,
   output arb_state_t             dbg_state
);

   localparam int IDW   = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   arb_state_t               state;
   logic [IDW-1:0]           rr_ptr;
   logic [IDW-1:0]           grant_id;
   logic [IDW-1:0]           next_ptr;
   logic                     cmd_write;
   logic [CNT_W-1:0]         wait_cnt;
   logic [NUM_REQ-1:0]       grant_onehot;

   logic [ADDRESS_WIDTH-1:0] bus_addr_q;
   logic                     bus_we_q;
   logic                     bus_re_q;
   logic [WIDTH-1:0]         bus_din_q;
   logic [NUM_REQ-1:0]       resp_valid_q;
   logic [WIDTH-1:0]         resp_rdata_q;

   logic [NUM_REQ-1:0]       pick_grant;
   logic [IDW-1:0]           pick_idx;
   logic                     pick_any;

   logic [ADDRESS_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [WIDTH-1:0]         wdata_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign wdata_arr[g] = bus.req_wdata[g*WIDTH +: WIDTH];
   end

   buff_uart_bus_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign grant_onehot = NUM_REQ'(1) << grant_id;
   assign next_ptr     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

   // Acceptance is combinational in IDLE so the requester sees ready in the cycle
   // the command is latched; held low while reset is asserted.
   assign bus.req_ready = (state == IDLE && resetn) ? pick_grant : '0;

   assign bus.grant_id           = grant_id;
   assign bus.resp_valid         = resp_valid_q;
   assign bus.resp_rdata         = resp_rdata_q;
   assign bus.bus_active_address = bus_addr_q;
   assign bus.bus_write_enable   = bus_we_q;
   assign bus.bus_read_enable    = bus_re_q;
   assign bus.bus_data_in        = bus_din_q;
   assign dbg_state              = state;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         cmd_write    <= 1'b0;
         wait_cnt     <= '0;
         bus_addr_q   <= '0;
         bus_we_q     <= 1'b0;
         bus_re_q     <= 1'b0;
         bus_din_q    <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
      end else begin
         case (state)
            // The bus registers double as the command latch: they are loaded on
            // accept and therefore present exactly during ISSUE.
            IDLE: begin
               if (pick_any) begin
                  grant_id   <= pick_idx;
                  cmd_write  <= bus.req_write[pick_idx];
                  bus_addr_q <= addr_arr[pick_idx];
                  bus_we_q   <= bus.req_write[pick_idx];
                  bus_re_q   <= !bus.req_write[pick_idx];
                  bus_din_q  <= bus.req_write[pick_idx] ? wdata_arr[pick_idx] : '0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               bus_addr_q <= '0;
               bus_we_q   <= 1'b0;
               bus_re_q   <= 1'b0;
               bus_din_q  <= '0;
               if (cmd_write) begin
                  resp_valid_q <= grant_onehot;
                  state        <= RESP;
               end else begin
                  wait_cnt <= CNT_W'(READ_LATENCY);
                  state    <= WAIT;
               end
            end
            // Read data is valid on the last WAIT cycle, READ_LATENCY after the strobe.
            WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
               if (wait_cnt == CNT_W'(1)) begin
                  resp_rdata_q <= bus.bus_data_out;
                  resp_valid_q <= grant_onehot;
                  state        <= RESP;
               end
            end
            RESP: begin
               resp_valid_q <= '0;
               rr_ptr       <= next_ptr;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
